// File: rtl/bc_buffer_pkg.sv
// Shared defaults and word type for the bidirectional controller/avoidance buffer.
package bc_buffer_pkg;

  localparam int BC_DATA_W = 16;
  localparam int BC_DEPTH  = 16;

  typedef logic [BC_DATA_W-1:0] bc_word_t;

endpackage

// File: rtl/bc_fifo.sv
// Single-clock first-word-fall-through FIFO with an occupancy counter.
// Optional BC_BUFFER_LEVEL_EN adds a registered occupancy output (level).
module bc_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_rdy,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_rdy
`ifdef BC_BUFFER_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Handshake: a transfer happens on a rising edge only when valid and rdy are
  // both high; valid never waits on rdy, and in_rdy never looks at out_rdy.
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              push, pop, empty, full;

  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  // Held low during reset so nothing is accepted while storage is being discarded.
  assign in_rdy    = rst & ~full;
  assign out_valid = ~empty;
  assign out_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign push      = in_valid & in_rdy;
  assign pop       = out_valid & out_rdy;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the counter alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

`ifdef BC_BUFFER_LEVEL_EN
  assign level = count_q;
`endif

endmodule

// File: rtl/bc_buffer.sv
// Two independent FWFT FIFOs between controller and avoidance logic.
// Optional BC_BUFFER_LEVEL_EN exposes avoid_level / ctrl_level occupancy outputs.
module bc_buffer
  import bc_buffer_pkg::*;
#(
  parameter int DATA_W = BC_DATA_W,
  parameter int DEPTH  = BC_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl_in_valid,
  input  logic [DATA_W-1:0] ctrl_in_data,
  output logic              ctrl_in_rdy,
  output logic              avoid_out_valid,
  output logic [DATA_W-1:0] avoid_out_data,
  input  logic              avoid_out_rdy,
  input  logic              avoid_in_valid,
  input  logic [DATA_W-1:0] avoid_in_data,
  output logic              avoid_in_rdy,
  output logic              ctrl_out_valid,
  output logic [DATA_W-1:0] ctrl_out_data,
  input  logic              ctrl_out_rdy
`ifdef BC_BUFFER_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] avoid_level,
  output logic [$clog2(DEPTH):0] ctrl_level
`endif
);

  bc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ctrl_to_avoid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (ctrl_in_valid),
    .in_data   (ctrl_in_data),
    .in_rdy    (ctrl_in_rdy),
    .out_valid (avoid_out_valid),
    .out_data  (avoid_out_data),
    .out_rdy   (avoid_out_rdy)
`ifdef BC_BUFFER_LEVEL_EN
    ,
    .level     (avoid_level)
`endif
  );

  bc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_avoid_to_ctrl (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (avoid_in_valid),
    .in_data   (avoid_in_data),
    .in_rdy    (avoid_in_rdy),
    .out_valid (ctrl_out_valid),
    .out_data  (ctrl_out_data),
    .out_rdy   (ctrl_out_rdy)
`ifdef BC_BUFFER_LEVEL_EN
    ,
    .level     (ctrl_level)
`endif
  );

endmodule

// File: tb/tb_bc_buffer.sv
// Directed self-checking bench for bc_buffer (default DATA_W=16, DEPTH=16).
module tb_bc_buffer;
  import bc_buffer_pkg::*;

  localparam int DEPTH = 16;

  logic     clk;
  logic     rst;
  logic     ctrl_in_valid, ctrl_in_rdy;
  bc_word_t ctrl_in_data;
  logic     avoid_out_valid, avoid_out_rdy;
  bc_word_t avoid_out_data;
  logic     avoid_in_valid, avoid_in_rdy;
  bc_word_t avoid_in_data;
  logic     ctrl_out_valid, ctrl_out_rdy;
  bc_word_t ctrl_out_data;
`ifdef BC_BUFFER_LEVEL_EN
  logic [$clog2(DEPTH):0] avoid_level, ctrl_level;
`endif

  int       total = 0;
  int       bad   = 0;
  bc_word_t exp_q[$];
  bc_word_t exp_w;
  int       n_acc;

  bc_buffer #(.DATA_W(BC_DATA_W), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .ctrl_in_valid   (ctrl_in_valid),
    .ctrl_in_data    (ctrl_in_data),
    .ctrl_in_rdy     (ctrl_in_rdy),
    .avoid_out_valid (avoid_out_valid),
    .avoid_out_data  (avoid_out_data),
    .avoid_out_rdy   (avoid_out_rdy),
    .avoid_in_valid  (avoid_in_valid),
    .avoid_in_data   (avoid_in_data),
    .avoid_in_rdy    (avoid_in_rdy),
    .ctrl_out_valid  (ctrl_out_valid),
    .ctrl_out_data   (ctrl_out_data),
    .ctrl_out_rdy    (ctrl_out_rdy)
`ifdef BC_BUFFER_LEVEL_EN
    ,
    .avoid_level     (avoid_level),
    .ctrl_level      (ctrl_level)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    ctrl_in_valid = 1'b0; ctrl_in_data = '0; avoid_out_rdy = 1'b0;
    avoid_in_valid = 1'b0; avoid_in_data = '0; ctrl_out_rdy = 1'b0;
    #2;
    // Reset state
    check("rst_ctrl_in_rdy", ctrl_in_rdy, 0);
    check("rst_avoid_in_rdy", avoid_in_rdy, 0);
    check("rst_avoid_out_valid", avoid_out_valid, 0);
    check("rst_ctrl_out_valid", ctrl_out_valid, 0);
    check("rst_avoid_out_data", avoid_out_data, 0);
    check("rst_ctrl_out_data", ctrl_out_data, 0);
    step(); step();
    rst = 1'b1;
    #1;
    check("post_rst_ctrl_in_rdy", ctrl_in_rdy, 1);
    check("post_rst_avoid_in_rdy", avoid_in_rdy, 1);

    // Single push while empty: visible only after the edge
    ctrl_in_valid = 1'b1; ctrl_in_data = 16'h0055;
    #1;
    check("nobypass_valid", avoid_out_valid, 0);
    check("nobypass_data", avoid_out_data, 0);
    step();
    ctrl_in_valid = 1'b0;
    check("single_valid", avoid_out_valid, 1);
    check("single_data", avoid_out_data, 16'h0055);
    avoid_out_rdy = 1'b1;
    step();
    avoid_out_rdy = 1'b0;
    check("single_drained_valid", avoid_out_valid, 0);
    check("single_drained_data", avoid_out_data, 0);
    // Pop on empty is ignored
    avoid_out_rdy = 1'b1;
    step();
    avoid_out_rdy = 1'b0;
    check("empty_pop_valid", avoid_out_valid, 0);

    // ctrl_in -> avoid_out ordered burst
    for (int i = 0; i < 10; i++) begin
      ctrl_in_valid = 1'b1; ctrl_in_data = bc_word_t'(16'h000A + i);
      step();
    end
    ctrl_in_valid = 1'b0;
    check("c2a_ctrl_out_valid_untouched", ctrl_out_valid, 0);
    avoid_out_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("c2a_valid", avoid_out_valid, 1);
      check("c2a_data", avoid_out_data, 32'h000A + i);
      step();
    end
    avoid_out_rdy = 1'b0;
    check("c2a_end_valid", avoid_out_valid, 0);

    // avoid_in -> ctrl_out ordered burst, other path stays idle
    for (int i = 0; i < 10; i++) begin
      avoid_in_valid = 1'b1; avoid_in_data = bc_word_t'(16'h000A + i);
      step();
      check("a2c_other_path_idle", avoid_out_valid, 0);
    end
    avoid_in_valid = 1'b0;
    ctrl_out_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("a2c_valid", ctrl_out_valid, 1);
      check("a2c_data", ctrl_out_data, 32'h000A + i);
      step();
    end
    ctrl_out_rdy = 1'b0;
    check("a2c_end_valid", ctrl_out_valid, 0);
    check("a2c_end_data", ctrl_out_data, 0);

    // Overfill: DEPTH+2 offers, only DEPTH accepted
    n_acc = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      check("full_in_rdy", ctrl_in_rdy, (n_acc < DEPTH) ? 1 : 0);
      ctrl_in_valid = 1'b1; ctrl_in_data = bc_word_t'(16'h0100 + i);
      if (n_acc < DEPTH) begin
        exp_q.push_back(bc_word_t'(16'h0100 + i));
        n_acc++;
      end
      step();
    end
    ctrl_in_valid = 1'b0;
`ifdef BC_BUFFER_LEVEL_EN
    check("full_level", avoid_level, DEPTH);
`endif
    avoid_out_rdy = 1'b1;
    while (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      check("full_drain_valid", avoid_out_valid, 1);
      check("full_drain_data", avoid_out_data, exp_w);
      step();
    end
    avoid_out_rdy = 1'b0;
    check("full_drain_end_valid", avoid_out_valid, 0);

    // Steady push+pop at occupancy 1 across several pointer wraps
    avoid_in_valid = 1'b1; avoid_in_data = 16'h0200;
    step();
    ctrl_out_rdy = 1'b1;
    for (int c = 0; c < 3 * DEPTH; c++) begin
      avoid_in_data = bc_word_t'(16'h0201 + c);
      check("wrap_valid", ctrl_out_valid, 1);
      check("wrap_data", ctrl_out_data, 32'h0200 + c);
      check("wrap_in_rdy", avoid_in_rdy, 1);
      step();
    end
    avoid_in_valid = 1'b0;
    check("wrap_last_data", ctrl_out_data, 32'h0200 + 3 * DEPTH);
`ifdef BC_BUFFER_LEVEL_EN
    check("wrap_level", ctrl_level, 1);
`endif
    step();
    ctrl_out_rdy = 1'b0;
    check("wrap_end_valid", ctrl_out_valid, 0);

    // Mid-operation reset discards stored words
    for (int i = 0; i < 5; i++) begin
      ctrl_in_valid = 1'b1; ctrl_in_data = bc_word_t'(16'h0300 + i);
      step();
    end
    ctrl_in_valid = 1'b0;
    check("pre_rst_valid", avoid_out_valid, 1);
    check("pre_rst_data", avoid_out_data, 16'h0300);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", avoid_out_valid, 0);
    check("mid_rst_data", avoid_out_data, 0);
    check("mid_rst_in_rdy", ctrl_in_rdy, 0);
    step();
    rst = 1'b1;
    #1;
    check("after_rst_in_rdy", ctrl_in_rdy, 1);
    check("after_rst_valid", avoid_out_valid, 0);
    step();
    check("after_rst_valid_edge", avoid_out_valid, 0);
    check("after_rst_data_edge", avoid_out_data, 0);
`ifdef BC_BUFFER_LEVEL_EN
    check("after_rst_level", avoid_level, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
